// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle request/acknowledge link.
// Synchronises REQ_T, captures DIN, hands it off over VALID/READY and answers with an ACK_T toggle.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_T,
    input  logic [DATA_W-1:0] DIN,
    input  logic              READY,
    output logic [DATA_W-1:0] DOUT,
    output logic              VALID,
    output logic              ACK_T,
    output logic              ERR,
    output logic [CNT_W-1:0]  EVT_CNT
);

    // state | meaning
    // IDLE  | no word held, waiting for a request toggle
    // HOLD  | DOUT holds a word the consumer has not taken yet

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("toggle_handshake_rx: SYNC_STAGES must be 2 or more");
        end
    endgenerate

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_req;
    logic                   req_prev;
    logic                   req_edge;
    logic                   capture;
    logic                   consume;

    // Whole design runs on the falling edge of CLK.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_T};
        end
    end

    assign sync_req = sync_q[SYNC_STAGES-1];
    assign req_edge = sync_req ^ req_prev;
    assign capture  = (state == IDLE) && req_edge;
    assign consume  = (state == HOLD) && READY;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_edge) state_nxt = HOLD;
            HOLD:    if (READY)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        VALID = (state == HOLD);
    end

    // A toggle seen while holding is absorbed here too, so it never becomes a second capture.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            req_prev <= 1'b0;
            DOUT     <= '0;
            ACK_T    <= 1'b0;
            ERR      <= 1'b0;
            EVT_CNT  <= '0;
        end else begin
            if (req_edge) begin
                req_prev <= sync_req;
            end
            if (capture) begin
                DOUT <= DIN;
            end
            if ((state == HOLD) && req_edge) begin
                ERR <= 1'b1;
            end
            if (consume) begin
                ACK_T   <= ~ACK_T;
                EVT_CNT <= EVT_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: directed and randomized transfers checked against
// a toggle-counting reference model of the receiver.
module tb_toggle_handshake_rx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              REQ_T;
    logic [DATA_W-1:0] DIN;
    logic              READY;
    logic [DATA_W-1:0] DOUT;
    logic              VALID;
    logic              ACK_T;
    logic              ERR;
    logic [CNT_W-1:0]  EVT_CNT;

    int n_checks = 0;
    int n_errors = 0;

    toggle_handshake_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ_T   (REQ_T),
        .DIN     (DIN),
        .READY   (READY),
        .DOUT    (DOUT),
        .VALID   (VALID),
        .ACK_T   (ACK_T),
        .ERR     (ERR),
        .EVT_CNT (EVT_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: counts raw request toggles as sampled on falling edges; a toggle
    // becomes visible SYNC_STAGES edges after it is sampled. Any visible toggle not yet
    // accounted for is either a new word (when empty) or a protocol violation (when full).
    logic [DATA_W-1:0] m_dout;
    logic              m_valid;
    logic              m_ack;
    logic              m_err;
    logic [CNT_W-1:0]  m_cnt;
    int                raw_toggles;
    int                handled;
    logic              last_sample;
    int                hist[$];

    always @(negedge CLK or posedge RST) begin
        int vis;
        if (RST) begin
            m_dout = '0; m_valid = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_cnt = '0;
            raw_toggles = 0; handled = 0; last_sample = 1'b0;
            hist = {};
            repeat (SYNC_STAGES) hist.push_back(0);
        end else begin
            vis = hist[0];
            if (REQ_T !== last_sample) raw_toggles++;
            last_sample = REQ_T;
            hist.push_back(raw_toggles);
            void'(hist.pop_front());
            if (!m_valid) begin
                if (vis != handled) begin
                    m_dout  = DIN;
                    m_valid = 1'b1;
                    handled = vis;
                end
            end else begin
                if (vis != handled) begin
                    m_err   = 1'b1;
                    handled = vis;
                end
                if (READY) begin
                    m_valid = 1'b0;
                    m_ack   = ~m_ack;
                    m_cnt   = m_cnt + 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid"}, 32'(VALID), 32'(m_valid));
        chk({tag, "_dout"}, 32'(DOUT), 32'(m_dout));
        chk({tag, "_ack"}, 32'(ACK_T), 32'(m_ack));
        chk({tag, "_err"}, 32'(ERR), 32'(m_err));
        chk({tag, "_cnt"}, 32'(EVT_CNT), 32'(m_cnt));
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
        chk_all("model");
    endtask

    task automatic drive_point();
        @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input logic [DATA_W-1:0] w, input bit rnd);
        logic a0;
        bit   done;
        a0   = ACK_T;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive_point();
            if (i == 0) begin
                DIN   = w;
                REQ_T = ~REQ_T;
            end
            READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (ACK_T !== a0) done = 1'b1;
        end
        chk("ack_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        REQ_T = 1'b0;
        DIN   = '0;
        READY = 1'b0;

        // reset asserted between edges: outputs clear immediately
        #1 RST = 1'b1;
        #2;
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_ack", 32'(ACK_T), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_cnt", 32'(EVT_CNT), 32'd0);
        repeat (2) @(negedge CLK);
        drive_point();
        RST   = 1'b0;
        READY = 1'b1;
        repeat (5) step();
        chk("idle_valid", 32'(VALID), 32'd0);
        chk("idle_cnt", 32'(EVT_CNT), 32'd0);

        // single transfer with READY already high
        drive_point();
        DIN   = 8'hA5;
        REQ_T = 1'b1;
        step();
        chk("single_n_valid", 32'(VALID), 32'd0);
        step();
        chk("single_n1_valid", 32'(VALID), 32'd0);
        step();
        chk("single_n2_valid", 32'(VALID), 32'd1);
        chk("single_n2_dout", 32'(DOUT), 32'hA5);
        step();
        chk("single_n3_valid", 32'(VALID), 32'd0);
        chk("single_n3_ack", 32'(ACK_T), 32'd1);
        chk("single_n3_cnt", 32'(EVT_CNT), 32'd1);
        chk("single_dout_kept", 32'(DOUT), 32'hA5);

        // mid-phase reset pulse clears everything at once
        drive_point();
        RST   = 1'b1;
        REQ_T = 1'b0;
        #1;
        chk("pulse_ack", 32'(ACK_T), 32'd0);
        chk("pulse_cnt", 32'(EVT_CNT), 32'd0);
        chk("pulse_dout", 32'(DOUT), 32'd0);
        #2 RST = 1'b0;
        repeat (3) step();

        // four back-to-back words
        for (int k = 1; k <= 4; k++) begin
            xfer(8'(k), 1'b0);
            chk("b2b_dout", 32'(DOUT), 32'(k));
        end
        chk("b2b_ack", 32'(ACK_T), 32'd0);
        chk("b2b_cnt", 32'(EVT_CNT), 32'd4);
        chk("b2b_err", 32'(ERR), 32'd0);

        // consumer stall
        drive_point();
        READY = 1'b0;
        DIN   = 8'h3C;
        REQ_T = ~REQ_T;
        repeat (3) step();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stall_valid", 32'(VALID), 32'd1);
            chk("stall_dout", 32'(DOUT), 32'h3C);
            chk("stall_ack", 32'(ACK_T), 32'd0);
        end
        drive_point();
        READY = 1'b1;
        step();
        chk("stall_done_valid", 32'(VALID), 32'd0);
        chk("stall_done_ack", 32'(ACK_T), 32'd1);
        chk("stall_done_cnt", 32'(EVT_CNT), 32'd5);

        // protocol violation: second toggle before the ack
        drive_point();
        READY = 1'b0;
        DIN   = 8'h11;
        REQ_T = ~REQ_T;
        repeat (3) step();
        drive_point();
        DIN   = 8'h22;
        REQ_T = ~REQ_T;
        repeat (3) step();
        chk("viol_dout", 32'(DOUT), 32'h11);
        chk("viol_err", 32'(ERR), 32'd1);
        chk("viol_valid", 32'(VALID), 32'd1);
        drive_point();
        READY = 1'b1;
        step();
        chk("viol_cnt", 32'(EVT_CNT), 32'd6);
        repeat (4) step();
        chk("viol_dropped_valid", 32'(VALID), 32'd0);
        chk("viol_dropped_cnt", 32'(EVT_CNT), 32'd6);
        chk("viol_err_sticky", 32'(ERR), 32'd1);

        // randomized words, random consumer stalls and idle gaps
        for (int k = 0; k < 20; k++) begin
            xfer(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        // counter wrap from a fresh reset
        drive_point();
        RST   = 1'b1;
        REQ_T = 1'b0;
        #2 RST = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 256; k++) xfer(8'($urandom), 1'b0);
        chk("wrap_cnt", 32'(EVT_CNT), 32'd0);
        chk("wrap_err", 32'(ERR), 32'd0);
        xfer(8'h5A, 1'b0);
        chk("post_wrap_cnt", 32'(EVT_CNT), 32'd1);
        chk("post_wrap_ack", 32'(ACK_T), 32'd1);

        // reset while holding a word
        drive_point();
        READY = 1'b0;
        DIN   = 8'h77;
        REQ_T = ~REQ_T;
        repeat (3) step();
        chk("hold_valid", 32'(VALID), 32'd1);
        drive_point();
        RST   = 1'b1;
        REQ_T = 1'b0;
        #1;
        chk("hold_rst_valid", 32'(VALID), 32'd0);
        chk("hold_rst_ack", 32'(ACK_T), 32'd0);
        chk("hold_rst_dout", 32'(DOUT), 32'd0);
        #2 RST = 1'b0;
        READY = 1'b1;
        repeat (4) step();
        chk("after_rst_ack", 32'(ACK_T), 32'd0);
        chk("after_rst_cnt", 32'(EVT_CNT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
